// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_pkg
// Purpose : Shared types and helpers for the EX->MEM elastic pipeline register.
//           Payload layout (default widths), controller state encoding and the
//           bubble-gating rule for control outputs.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package ex_mem_pkg;

  // Mirrors of the top-level parameter defaults, used to size the payload type.
  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int RESULT_SRC_W = 2;
  localparam int LS_MODE_W    = 3;

  typedef struct packed {
    logic [DATA_W-1:0]       alu_result;
    logic [DATA_W-1:0]       write_data;
    logic [DATA_W-1:0]       pc_plus4;
    logic                    mem_write;
    logic                    mem_read;
    logic                    reg_write;
    logic [REG_ADDR_W-1:0]   rd;
    logic [RESULT_SRC_W-1:0] result_src;
    logic [LS_MODE_W-1:0]    ls_mode;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } ex_mem_state_t;

  // Control strobes must never fire from a bubble: a stale main entry keeps
  // its data visible but its side-effecting controls are forced low.
  function automatic logic gate_ctrl(input logic valid, input logic ctrl);
    return valid & ctrl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_elastic_pipe_skid_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : skid_buffer_ctrl
// Purpose : Handshake controller for a main register plus one-entry skid
//           register. Owns the EMPTY/BUSY/FULL state, the registered in_ready
//           and the per-cycle load enables for the payload registers.
// Ports   : clk, rst (async, active-high), flush (sync kill)
//           in_valid / in_ready      upstream handshake (in_ready registered)
//           out_valid / out_ready    downstream handshake
//           load_main_from_in, load_main_from_skid, load_skid   load enables
// Rev     : 1.0  initial release
// ============================================================================
module skid_buffer_ctrl
  import ex_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic load_main_from_in,
  output logic load_main_from_skid,
  output logic load_skid
);

  ex_mem_state_t state_q;
  ex_mem_state_t state_next;
  logic          in_ready_q;
  logic          accept;
  logic          drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  // State register. in_ready is computed from the next state so that it is a
  // pure flop output with no path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  // Next-state logic. Flush overrides every transition.
  always_comb begin
    state_next = state_q;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_next = BUSY;
        BUSY: begin
          if (accept && !drain)      state_next = FULL;
          else if (!accept && drain) state_next = EMPTY;
        end
        FULL:    if (drain) state_next = BUSY;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output logic: load enables are suppressed during flush so nothing offered
  // in the flush cycle is captured.
  always_comb begin
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: load_main_from_in = accept;
        BUSY: begin
          load_main_from_in = accept & drain;
          load_skid         = accept & ~drain;
        end
        FULL:    load_main_from_skid = drain;
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_elastic_pipe
// Purpose : EX->MEM pipeline register with valid/ready handshake, one-entry
//           skid buffer (full throughput, registered in_ready), synchronous
//           flush, bubble gating of control strobes and a saturating
//           stall-cycle counter.
// Ports   : clk, rst (async, active-high), flush
//           in_valid/in_ready, *_e      EX-side payload and handshake
//           out_valid/out_ready, *_m    MEM-side payload and handshake
//           stall_cycles                count of out_valid & !out_ready cycles
// Rev     : 1.0  initial release
// ============================================================================
module ex_mem_elastic_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2,
  parameter int LS_MODE_WIDTH    = 3,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       alu_result_e,
  input  logic [DATA_WIDTH-1:0]       write_data_e,
  input  logic [DATA_WIDTH-1:0]       pc_plus4_e,
  input  logic                        mem_write_e,
  input  logic                        mem_read_e,
  input  logic                        reg_write_e,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_e,
  input  logic [RESULT_SRC_WIDTH-1:0] result_src_e,
  input  logic [LS_MODE_WIDTH-1:0]    ls_mode_e,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       alu_result_m,
  output logic [DATA_WIDTH-1:0]       write_data_m,
  output logic [DATA_WIDTH-1:0]       pc_plus4_m,
  output logic                        mem_write_m,
  output logic                        mem_read_m,
  output logic                        reg_write_m,
  output logic [REG_ADDR_WIDTH-1:0]   rd_m,
  output logic [RESULT_SRC_WIDTH-1:0] result_src_m,
  output logic [LS_MODE_WIDTH-1:0]    ls_mode_m,
  output logic [STALL_CNT_WIDTH-1:0]  stall_cycles
);

  // Flat payload vector sized from the module parameters so that non-default
  // widths work; field order matches ex_mem_payload_t.
  localparam int PAYLOAD_W = 3*DATA_WIDTH + 3 + REG_ADDR_WIDTH
                           + RESULT_SRC_WIDTH + LS_MODE_WIDTH;

  logic [PAYLOAD_W-1:0]       in_bus;
  logic [PAYLOAD_W-1:0]       main_q;
  logic [PAYLOAD_W-1:0]       skid_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;
  logic                       load_main_from_in;
  logic                       load_main_from_skid;
  logic                       load_skid;
  logic                       mem_write_raw;
  logic                       mem_read_raw;
  logic                       reg_write_raw;

  skid_buffer_ctrl u_ctrl (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .load_main_from_in   (load_main_from_in),
    .load_main_from_skid (load_main_from_skid),
    .load_skid           (load_skid)
  );

  assign in_bus = {alu_result_e, write_data_e, pc_plus4_e,
                   mem_write_e, mem_read_e, reg_write_e,
                   rd_e, result_src_e, ls_mode_e};

  // Payload registers. Main is never cleared by flush: data fields keep their
  // last value and only the control strobes are gated by out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_from_in)        main_q <= in_bus;
      else if (load_main_from_skid) main_q <= skid_q;
      if (load_skid)                skid_q <= in_bus;
    end
  end

  // Saturating stall counter; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_q <= stall_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign {alu_result_m, write_data_m, pc_plus4_m,
          mem_write_raw, mem_read_raw, reg_write_raw,
          rd_m, result_src_m, ls_mode_m} = main_q;

  assign mem_write_m  = gate_ctrl(out_valid, mem_write_raw);
  assign mem_read_m   = gate_ctrl(out_valid, mem_read_raw);
  assign reg_write_m  = gate_ctrl(out_valid, reg_write_raw);
  assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mem_elastic_pipe
// Purpose : Directed self-checking bench for ex_mem_elastic_pipe. A second
//           instance with a 4-bit stall counter shares all stimulus and is
//           used for the saturation scenario.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ex_mem_elastic_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] alu_e, wd_e, pc_e;
  logic        mw_e, mr_e, rw_e;
  logic [4:0]  rd_e;
  logic [1:0]  rs_e;
  logic [2:0]  ls_e;

  logic        in_ready, out_valid;
  logic [31:0] alu_m, wd_m, pc_m;
  logic        mw_m, mr_m, rw_m;
  logic [4:0]  rd_m;
  logic [1:0]  rs_m;
  logic [2:0]  ls_m;
  logic [15:0] stall;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_alu_m, s_wd_m, s_pc_m;
  logic        s_mw_m, s_mr_m, s_rw_m;
  logic [4:0]  s_rd_m;
  logic [1:0]  s_rs_m;
  logic [2:0]  s_ls_m;
  logic [3:0]  s_stall;

  logic [108:0] bus_m, bus_s;
  assign bus_m = {alu_m, wd_m, pc_m, mw_m, mr_m, rw_m, rd_m, rs_m, ls_m};
  assign bus_s = {s_alu_m, s_wd_m, s_pc_m, s_mw_m, s_mr_m, s_rw_m, s_rd_m, s_rs_m, s_ls_m};

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_elastic_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_e(alu_e), .write_data_e(wd_e), .pc_plus4_e(pc_e),
    .mem_write_e(mw_e), .mem_read_e(mr_e), .reg_write_e(rw_e),
    .rd_e(rd_e), .result_src_e(rs_e), .ls_mode_e(ls_e),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_m(alu_m), .write_data_m(wd_m), .pc_plus4_m(pc_m),
    .mem_write_m(mw_m), .mem_read_m(mr_m), .reg_write_m(rw_m),
    .rd_m(rd_m), .result_src_m(rs_m), .ls_mode_m(ls_m),
    .stall_cycles(stall)
  );

  ex_mem_elastic_pipe #(.STALL_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .alu_result_e(alu_e), .write_data_e(wd_e), .pc_plus4_e(pc_e),
    .mem_write_e(mw_e), .mem_read_e(mr_e), .reg_write_e(rw_e),
    .rd_e(rd_e), .result_src_e(rs_e), .ls_mode_e(ls_e),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_result_m(s_alu_m), .write_data_m(s_wd_m), .pc_plus4_m(s_pc_m),
    .mem_write_m(s_mw_m), .mem_read_m(s_mr_m), .reg_write_m(s_rw_m),
    .rd_m(s_rd_m), .result_src_m(s_rs_m), .ls_mode_m(s_ls_m),
    .stall_cycles(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected MEM-side payload for a beat built by drive() from value a,
  // with control strobes gated by v.
  function automatic logic [108:0] exp_bus(input logic [31:0] a, input logic mw,
                                           input logic rw, input logic v);
    return {a, a ^ 32'hFFFF0000, a + 32'd4, mw & v, a[3] & v, rw & v,
            a[4:0], a[1:0], a[2:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic mw, input logic rw);
    in_valid = 1'b1;
    alu_e    = a;
    wd_e     = a ^ 32'hFFFF0000;
    pc_e     = a + 32'd4;
    mw_e     = mw;
    mr_e     = a[3];
    rw_e     = rw;
    rd_e     = a[4:0];
    rs_e     = a[1:0];
    ls_e     = a[2:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 10", {in_ready, out_valid});
    end
    n_checks++;
    if (bus_m !== '0) begin
      n_fail++; $display("FAIL reset_payload: got %h expected 0", bus_m);
    end
    n_checks++;
    if (stall !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall);
    end
    n_checks++;
    if ({s_in_ready, s_out_valid, s_stall} !== 6'b10_0000) begin
      n_fail++; $display("FAIL reset_small: got %b expected 100000", {s_in_ready, s_out_valid, s_stall});
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h10 * 32'(i + 1);
      drive(a, 1'b0, 1'b1);
      step();
      n_checks++;
      if ({out_valid, in_ready, bus_m} !== {2'b11, exp_bus(a, 1'b0, 1'b1, 1'b1)}) begin
        n_fail++; $display("FAIL stream_beat%0d: got %b/%b %h expected 1/1 %h",
                           i, out_valid, in_ready, bus_m, exp_bus(a, 1'b0, 1'b1, 1'b1));
      end
    end
    idle();
    step();
    n_checks++;
    if ({out_valid, stall} !== {1'b0, 16'd0}) begin
      n_fail++; $display("FAIL stream_drain: got valid=%b stall=%0d expected valid=0 stall=0", out_valid, stall);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    drive(32'h11, 1'b0, 1'b1);
    step();
    drive(32'h22, 1'b0, 1'b1);
    out_ready = 1'b0;
    step();
    n_checks++;
    if ({in_ready, alu_m} !== {1'b0, 32'h11}) begin
      n_fail++; $display("FAIL bp_skid_fill: got ready=%b alu=%h expected ready=0 alu=11", in_ready, alu_m);
    end
    idle();
    step();
    step();
    n_checks++;
    if ({out_valid, in_ready, stall, alu_m} !== {2'b10, 16'd3, 32'h11}) begin
      n_fail++; $display("FAIL bp_hold: got valid=%b ready=%b stall=%0d alu=%h expected 1 0 3 11",
                         out_valid, in_ready, stall, alu_m);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({out_valid, in_ready, stall, bus_m} !== {2'b11, 16'd3, exp_bus(32'h22, 1'b0, 1'b1, 1'b1)}) begin
      n_fail++; $display("FAIL bp_skid_out: got valid=%b ready=%b stall=%0d bus=%h expected 1 1 3 %h",
                         out_valid, in_ready, stall, bus_m, exp_bus(32'h22, 1'b0, 1'b1, 1'b1));
    end
    step();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_empty: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(32'h50, 1'b1, 1'b1);
    step();
    drive(32'h60, 1'b1, 1'b1);
    step();
    n_checks++;
    if ({out_valid, in_ready, mw_m} !== 3'b101) begin
      n_fail++; $display("FAIL flush_full: got %b expected 101", {out_valid, in_ready, mw_m});
    end
    flush = 1'b1;
    drive(32'h70, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    idle();
    n_checks++;
    if ({out_valid, in_ready, bus_m} !== {2'b01, exp_bus(32'h50, 1'b1, 1'b1, 1'b0)}) begin
      n_fail++; $display("FAIL flush_kill: got valid=%b ready=%b bus=%h expected 0 1 %h",
                         out_valid, in_ready, bus_m, exp_bus(32'h50, 1'b1, 1'b1, 1'b0));
    end
    step();
    n_checks++;
    if ({out_valid, alu_m} !== {1'b0, 32'h50}) begin
      n_fail++; $display("FAIL flush_no_capture: got valid=%b alu=%h expected 0 50", out_valid, alu_m);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1;
    drive(32'hDEAD, 1'b0, 1'b1);
    step();
    n_checks++;
    if ({out_valid, rw_m, mr_m} !== 3'b111) begin
      n_fail++; $display("FAIL bubble_live: got %b expected 111", {out_valid, rw_m, mr_m});
    end
    idle();
    step();
    n_checks++;
    if ({out_valid, bus_m} !== {1'b0, exp_bus(32'hDEAD, 1'b0, 1'b1, 1'b0)}) begin
      n_fail++; $display("FAIL bubble_gate: got valid=%b bus=%h expected 0 %h",
                         out_valid, bus_m, exp_bus(32'hDEAD, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    drive(32'h33, 1'b0, 1'b1);
    step();
    idle();
    repeat (15) step();
    n_checks++;
    if ({s_stall, stall} !== {4'd15, 16'd15}) begin
      n_fail++; $display("FAIL sat_reach: got small=%0d big=%0d expected 15 15", s_stall, stall);
    end
    repeat (5) step();
    n_checks++;
    if ({s_stall, stall} !== {4'd15, 16'd20}) begin
      n_fail++; $display("FAIL sat_hold: got small=%0d big=%0d expected 15 20", s_stall, stall);
    end
    n_checks++;
    if ({s_out_valid, s_in_ready, bus_s} !== {2'b11, exp_bus(32'h33, 1'b0, 1'b1, 1'b1)}) begin
      n_fail++; $display("FAIL sat_payload: got %b %b %h expected 1 1 %h",
                         s_out_valid, s_in_ready, bus_s, exp_bus(32'h33, 1'b0, 1'b1, 1'b1));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive(32'h44, 1'b1, 1'b1);
    step();
    drive(32'h55, 1'b1, 1'b1);
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, stall, bus_m} !== {2'b01, 16'd0, 109'd0}) begin
      n_fail++; $display("FAIL async_rst: got valid=%b ready=%b stall=%0d bus=%h expected 0 1 0 0",
                         out_valid, in_ready, stall, bus_m);
    end
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h66, 1'b0, 1'b1);
    step();
    n_checks++;
    if ({out_valid, bus_m} !== {1'b1, exp_bus(32'h66, 1'b0, 1'b1, 1'b1)}) begin
      n_fail++; $display("FAIL async_rst_first_accept: got valid=%b bus=%h expected 1 %h",
                         out_valid, bus_m, exp_bus(32'h66, 1'b0, 1'b1, 1'b1));
    end
    idle();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_e = '0; wd_e = '0; pc_e = '0;
    mw_e = 1'b0; mr_e = 1'b0; rw_e = 1'b0;
    rd_e = '0; rs_e = '0; ls_e = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
